// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: measures mark/space durations in 10 us ticks and
// assembles the 32-bit code word, flagging repeat frames and malformed frames.
module nec_ir_decoder #(
  parameter int CLK_HZ    = 50_000_000,
  parameter bit CHECK_INV = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_in,
  output logic [31:0] code,
  output logic        code_valid,
  output logic        repeat_pulse,
  output logic        err
);

  localparam int DIV = CLK_HZ / 100_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [10:0] DUR_MAX  = 11'd2047;
  localparam logic [10:0] LEAD_LO  = 11'd800;
  localparam logic [10:0] LEAD_HI  = 11'd1000;
  localparam logic [10:0] DATA_LO  = 11'd400;
  localparam logic [10:0] DATA_HI  = 11'd500;
  localparam logic [10:0] RPT_LO   = 11'd180;
  localparam logic [10:0] RPT_HI   = 11'd270;
  localparam logic [10:0] SHORT_LO = 11'd40;
  localparam logic [10:0] SHORT_HI = 11'd75;
  localparam logic [10:0] LONG_LO  = 11'd140;
  localparam logic [10:0] LONG_HI  = 11'd190;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_MARK
  } state_t;

  function automatic logic in_win(input logic [10:0] d, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  logic          sync1_q, sync2_q, prev_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [10:0]   dur_q, dur_d;
  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   code_q, code_d;
  logic          cv_q, cv_d, rp_q, rp_d, err_q, err_d;
  logic          edge_w, rise_w, fall_w, tick_w;
  logic          short_w, long_w, inv_ok_w, bad;

  assign edge_w = sync2_q ^ prev_q;
  assign rise_w = edge_w & sync2_q;
  assign fall_w = edge_w & ~sync2_q;
  assign tick_w = (pre_q == PW'(DIV - 1));

  assign short_w  = in_win(dur_q, SHORT_LO, SHORT_HI);
  assign long_w   = in_win(dur_q, LONG_LO, LONG_HI);
  assign inv_ok_w = !CHECK_INV || ((shift_q[31:24] == ~shift_q[23:16]) &&
                                   (shift_q[15:8] == ~shift_q[7:0]));

  assign code         = code_q;
  assign code_valid   = cv_q;
  assign repeat_pulse = rp_q;
  assign err          = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      pre_q   <= '0;
      dur_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      code_q  <= '0;
      cv_q    <= 1'b0;
      rp_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pre_q   <= pre_d;
      dur_q   <= dur_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      cv_q    <= cv_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
    end
  end

  // Both counters restart on every edge so dur_q is the length of the level that just ended.
  always_comb begin
    pre_d = pre_q;
    dur_d = dur_q;
    if (edge_w) begin
      pre_d = '0;
      dur_d = '0;
    end else if (tick_w) begin
      pre_d = '0;
      if (dur_q != DUR_MAX) dur_d = dur_q + 11'd1;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    code_d  = code_q;
    cv_d    = 1'b0;
    rp_d    = 1'b0;
    err_d   = 1'b0;
    bad     = 1'b0;
    case (state_q)
      IDLE: if (fall_w) state_d = LEAD_MARK;
      LEAD_MARK: if (edge_w) begin
        if (rise_w && in_win(dur_q, LEAD_LO, LEAD_HI)) state_d = LEAD_SPACE;
        else bad = 1'b1;
      end
      LEAD_SPACE: if (edge_w) begin
        if (fall_w && in_win(dur_q, DATA_LO, DATA_HI)) begin
          cnt_d   = '0;
          state_d = BIT_MARK;
        end else if (fall_w && in_win(dur_q, RPT_LO, RPT_HI)) begin
          state_d = RPT_MARK;
        end else bad = 1'b1;
      end
      BIT_MARK: if (edge_w) begin
        if (rise_w && short_w) state_d = BIT_SPACE;
        else bad = 1'b1;
      end
      BIT_SPACE: if (edge_w) begin
        if (fall_w && (short_w || long_w)) begin
          shift_d = {shift_q[30:0], long_w};
          cnt_d   = cnt_q + 6'd1;
          state_d = (cnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
        end else bad = 1'b1;
      end
      STOP_MARK: if (edge_w) begin
        if (rise_w && short_w && inv_ok_w) begin
          code_d  = shift_q;
          cv_d    = 1'b1;
          state_d = IDLE;
        end else bad = 1'b1;
      end
      RPT_MARK: if (edge_w) begin
        if (rise_w && short_w) begin
          rp_d    = 1'b1;
          state_d = IDLE;
        end else bad = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A level stuck past the counter range abandons the frame exactly once.
    if (state_q != IDLE && !edge_w && dur_q == DUR_MAX) bad = 1'b1;
    if (bad) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

endmodule
